// File: rtl/mem_stage.sv
// =============================================================================
// Module   : mem_stage
// Purpose  : MIPS memory-access stage with a request/ack data-memory port,
//            write-back select, MEM/WB register and EX/MEM forwarding outputs.
// Revision : 1.0
// =============================================================================
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [138:0] EX_MEM,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  input  logic [31:0]  dmem_rdata,
  input  logic         dmem_ack,
  output logic         mem_stall,
  output logic [4:0]   EX_MEM_Rd,
  output logic         EX_MEM_RegWrite,
  output logic [31:0]  EX_MEM_RdData,
  output logic [4:0]   MEM_WB_Rd,
  output logic         MEM_WB_RegWrite,
  output logic [31:0]  MEM_WB_RdData,
  output logic         align_err,
  output logic         bus_err,
  output logic [31:0]  stall_cycles
);

  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;

  logic [31:0] w_sdata, w_alu, w_pc4, w_ludata;
  logic [4:0]  w_rd;
  logic        w_mem_read, w_mem_write, w_reg_write, w_luop;
  logic [1:0]  w_mem_to_reg;
  logic        w_access, w_is_load, w_aligned, w_acc_ok, w_misaligned;
  logic        w_ack, w_abort, w_stall, w_wb_rw;
  logic [31:0] w_wb_data, w_fwd_data;

  assign w_sdata      = EX_MEM[31:0];
  assign w_alu        = EX_MEM[63:32];
  assign w_rd         = EX_MEM[68:64];
  assign w_mem_read   = EX_MEM[69];
  assign w_mem_write  = EX_MEM[70];
  assign w_reg_write  = EX_MEM[71];
  assign w_mem_to_reg = EX_MEM[73:72];
  assign w_pc4        = EX_MEM[105:74];
  assign w_ludata     = EX_MEM[137:106];
  assign w_luop       = EX_MEM[138];

  // MemWrite takes precedence when both access bits are set.
  assign w_access     = w_mem_read | w_mem_write;
  assign w_is_load    = w_mem_read & ~w_mem_write;
  assign w_aligned    = (w_alu[1:0] == 2'b00);
  assign w_acc_ok     = w_access & w_aligned;
  assign w_misaligned = w_access & ~w_aligned;
  assign w_ack        = dmem_ack & w_acc_ok;

  function automatic logic [31:0] wb_select(
    input logic        luop,
    input logic [31:0] ludata,
    input logic [1:0]  m2r,
    input logic [31:0] alu,
    input logic [31:0] ld,
    input logic [31:0] pc4
  );
    logic [31:0] v;
    if (luop) begin
      v = ludata;
    end else begin
      case (m2r)
        2'b00:   v = alu;
        2'b01:   v = ld;
        2'b10:   v = pc4;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_ok && !w_ack) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 16'd1;
        end
      end
      ST_WAIT: begin
        if (w_ack || !w_acc_ok) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == c_timeout) begin
          // Ack on the timeout cycle is handled above, so ack wins.
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  assign w_stall    = w_acc_ok & ~w_ack & ~w_abort;
  assign w_wb_rw    = w_reg_write & ~w_abort & ~(w_misaligned & w_is_load);
  assign w_wb_data  = wb_select(w_luop, w_ludata, w_mem_to_reg, w_alu, dmem_rdata, w_pc4);
  assign w_fwd_data = wb_select(w_luop, w_ludata, w_mem_to_reg, w_alu, w_alu, w_pc4);

  assign dmem_req        = w_acc_ok;
  assign dmem_we         = w_mem_write;
  assign dmem_addr       = w_alu;
  assign dmem_wdata      = w_sdata;
  assign mem_stall       = w_stall;
  assign EX_MEM_Rd       = w_rd;
  assign EX_MEM_RegWrite = w_reg_write & ~w_mem_read;
  assign EX_MEM_RdData   = w_fwd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 16'd0;
      MEM_WB_Rd       <= 5'd0;
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_RdData   <= 32'd0;
      align_err       <= 1'b0;
      bus_err         <= 1'b0;
      stall_cycles    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall) begin
        MEM_WB_Rd       <= 5'd0;
        MEM_WB_RegWrite <= 1'b0;
        MEM_WB_RdData   <= 32'd0;
        stall_cycles    <= stall_cycles + 32'd1;
      end else begin
        MEM_WB_Rd       <= w_rd;
        MEM_WB_RegWrite <= w_wb_rw;
        MEM_WB_RdData   <= w_wb_data;
      end
      if (w_misaligned) align_err <= 1'b1;
      if (w_abort)      bus_err   <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. Consumes the 139-bit `EX_MEM` bundle that the execute stage registers, performs the word load or store against a variable-latency data memory through a request/acknowledge handshake, and selects the write-back value. It registers the `MEM_WB` outputs, and drives the EX_MEM-side forwarding signals back to the execute stage. While an access is outstanding it stalls the upstream pipeline and inserts bubbles into write-back.

## Interface
- `TIMEOUT`, 255: maximum cycles the stage waits for `dmem_ack` before aborting an access (1..65535).
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `EX_MEM` in 139: execute-stage bundle, with these fields:
  - [31:0] store data
  - [63:32] ALU result / address
  - [68:64] write register
  - [69] MemRead
  - [70] MemWrite
  - [71] RegWrite
  - [73:72] MemToReg
  - [105:74] PC_Plus4
  - [137:106] LUData
  - [138] LUOp
- `dmem_req` out 1: access request, level, held until ack.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: byte address (ALU result).
- `dmem_wdata` out 32: store data.
- `dmem_rdata` in 32: load data, valid when `dmem_ack`=1.
- `dmem_ack` in 1: access complete; only meaningful while `dmem_req`=1.
- `mem_stall` out 1: 1 = hold PC, IF/ID, ID/EX and EX_MEM this cycle.
- `EX_MEM_Rd` out 5: forwarding, = `EX_MEM`[68:64].
- `EX_MEM_RegWrite` out 1: forwarding, = `EX_MEM`[71] & ~(MemRead).
- `EX_MEM_RdData` out 32: forwarding value, non-load write-back select of the current bundle.
- `MEM_WB_Rd` out 5: registered write register.
- `MEM_WB_RegWrite` out 1: registered write enable.
- `MEM_WB_RdData` out 32: registered write-back data.
- `align_err` out 1: sticky, misaligned access seen.
- `bus_err` out 1: sticky, timeout seen.
- `stall_cycles` out 32: count of cycles with `mem_stall`=1, wraps at 2^32.

## Operation
- Access = MemRead | MemWrite. If both bits are set, the access is treated as a store.
- Write-back select:
  - LUOp=1 → LUData, regardless of MemToReg.
  - Otherwise MemToReg 00 → ALU result, 01 → load data, 10 → PC_Plus4, 11 → 0.
  - `EX_MEM_RdData` uses the same select with load data replaced by the ALU result.
- Loads are not forwarded from this stage; the hazard unit stalls for load-use.
- Misaligned access (addr[1:0]≠0):
  - No request is issued, no stall occurs, and `align_err` is set.
  - The instruction retires with RegWrite forced to 0 for loads; stores are dropped.
- FSM states:
  - IDLE:
    - Aligned access present → `dmem_req`=1 combinationally.
    - `dmem_ack`=1 in the same cycle → complete, stay IDLE.
    - Otherwise go to WAIT, counter=1.
  - WAIT:
    - `dmem_req`=1.
    - `dmem_ack`=1 → complete, go to IDLE.
    - Otherwise, counter==TIMEOUT → abort: set `bus_err`, retire with RegWrite=0, go to IDLE.
    - Otherwise counter+1.
- `mem_stall` = aligned access & ~`dmem_ack` & ~abort.
- On the completion or abort cycle, `mem_stall`=0, so upstream advances at that edge.
- `dmem_addr`, `dmem_we` and `dmem_wdata` are driven combinationally from `EX_MEM`. They are stable during WAIT because upstream is held.
- MEM_WB update, every edge:
  - Stalled cycle → bubble (RegWrite=0, Rd=0, RdData=0).
  - Otherwise → Rd, RegWrite (with the forcing rules above), and selected data; load data is taken from `dmem_rdata` at the ack edge.

## Timing
- Reset (synchronous, dominant over all other events):
  - State → IDLE, counter → 0.
  - All `MEM_WB_*` → 0; `align_err`, `bus_err`, `stall_cycles` → 0.
  - Combinational outputs follow `EX_MEM`; the execute stage also resets `EX_MEM` to 0, so `dmem_req`=0.
- Reset during WAIT drops `dmem_req` in the following cycle. The memory treats a dropped request as an abort, and a late ack is ignored.
- Latency:
  - Zero-wait memory: `MEM_WB` valid 1 edge after `EX_MEM` presents the instruction, with no stall.
  - N-cycle ack: N stall cycles, then `MEM_WB` is written at the ack edge.
- Ack arriving in the same cycle that the counter reaches TIMEOUT: ack wins, and `bus_err` is not set.
- `stall_cycles` increments on every edge where `mem_stall`=1 and `reset`=0.

## Test plan
- Zero-wait load:
  - Stimulus: EX_MEM addr=0x10, MemRead=1, MemToReg=01, Rd=8, RegWrite=1; ack in the same cycle with rdata=0xDEADBEEF.
  - Required: `mem_stall` never 1; next edge MEM_WB_Rd=8, RegWrite=1, RdData=0xDEADBEEF.
- 3-cycle store:
  - Stimulus: addr=0x20, wdata=0x12345678, MemWrite=1; ack on the 4th cycle.
  - Required: `dmem_req`=1 and `dmem_we`=1 for 4 cycles; `mem_stall`=1 for 3 cycles; 3 bubbles; `stall_cycles`=3.
- Timeout:
  - Stimulus: TIMEOUT=4, load with no ack.
  - Required: 4 stall cycles, then `bus_err`=1, MEM_WB_RegWrite=0, state IDLE; the next instruction proceeds.
- Misaligned load:
  - Stimulus: addr=0x13.
  - Required: `dmem_req`=0, `mem_stall`=0, `align_err`=1, MEM_WB_RegWrite=0.
- Select and forwarding:
  - LUOp=1 with LUData=0xABCD0000 and MemToReg=10 → RdData=0xABCD0000.
  - MemToReg=10 with PC_Plus4=0x404 → RdData=0x404, and `EX_MEM_RdData`=0x404 combinationally.
- Reset mid-WAIT:
  - Stimulus: assert `reset` on the 2nd wait cycle.
  - Required: next cycle `dmem_req`=0, all MEM_WB outputs 0, errors 0, `stall_cycles`=0.
